// File: rtl/matrix_accel_sched.sv
// Job scheduler for a KERNEL_SIZE^2 multiplier array behind a crossbar.
// Optional WAIT watchdog: define MATRIX_ACCEL_SCHED_TIMEOUT_EN.
module matrix_accel_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int REST_ADDR   = KERNEL_SIZE**4,
  parameter int ADDR_WIDTH  = $clog2(REST_ADDR),
  parameter int SETTLE      = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                cmd_base_addr,
  input  logic [ADDR_WIDTH-1:0]                cmd_passes,
  input  logic                                 cmd_direct,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]   mStart,
  output logic [ADDR_WIDTH-1:0]                AddressSelect,
  output logic                                 direct,
  input  logic                                 finalReady,
  input  logic [DATA_WIDTH-1:0]                finalAccumulate,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [DATA_WIDTH-1:0]                res_data,
  output logic                                 res_last,
  output logic                                 busy,
  output logic                                 err_timeout
);

  localparam int NMUL = KERNEL_SIZE * KERNEL_SIZE;
  localparam int SW   = $clog2(SETTLE + 1);

  localparam logic [ADDR_WIDTH:0]   REST_W    = (ADDR_WIDTH+1)'(REST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REST_ADDR - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [SW-1:0]         SET_LAST  = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_SETTLE,
    ST_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] passes_q, passes_d;
  logic [ADDR_WIDTH-1:0] pass_q, pass_d;
  logic                  direct_q, direct_d;
  logic                  arm_q, arm_d;
  logic [SW-1:0]         set_q, set_d;
  logic                  rv_q, rv_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  rl_q, rl_d;

`ifdef MATRIX_ACCEL_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // A returning result in the same cycle blocks any new command.
  assign cmd_ready     = (state_q == ST_IDLE) && !(rv_q && res_ready);
  assign mStart        = {NMUL{state_q == ST_ISSUE}};
  assign AddressSelect = addr_q;
  assign direct        = direct_q;
  assign res_valid     = rv_q;
  assign res_data      = rd_q;
  assign res_last      = rl_q;
  assign busy          = (state_q != ST_IDLE);
`ifdef MATRIX_ACCEL_SCHED_TIMEOUT_EN
  assign err_timeout   = err_q;
`else
  assign err_timeout   = 1'b0;
`endif

  // Next-state and datapath register updates for the job sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    passes_d = passes_q;
    pass_d   = pass_q;
    direct_d = direct_q;
    arm_d    = arm_q;
    set_d    = set_q;
    rv_d     = rv_q;
    rd_d     = rd_q;
    rl_d     = rl_q;
`ifdef MATRIX_ACCEL_SCHED_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          passes_d = (cmd_passes == '0) ? ONE_A : cmd_passes;
          direct_d = cmd_direct;
          addr_d   = ({1'b0, cmd_base_addr} >= REST_W) ? '0
                                                       : cmd_base_addr;
          pass_d   = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        arm_d   = 1'b0;
        state_d = ST_ARM;
      end
      // finalReady may still be high from the previous job here.
      ST_ARM: begin
        if (arm_q) begin
          state_d = ST_WAIT;
`ifdef MATRIX_ACCEL_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          arm_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (finalReady) begin
          set_d   = '0;
          state_d = ST_SETTLE;
        end
`ifdef MATRIX_ACCEL_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      ST_SETTLE: begin
        if (set_q == SET_LAST) begin
          rd_d    = finalAccumulate;
          rv_d    = 1'b1;
          rl_d    = (pass_q == passes_q - ONE_A);
          state_d = ST_OUT;
        end else begin
          set_d = set_q + SW'(1);
        end
      end
      // Later passes reuse the products: only the crossbar moves.
      ST_OUT: begin
        if (res_ready) begin
          rv_d = 1'b0;
          if (rl_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE_A;
            pass_d  = pass_q + ONE_A;
            set_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      passes_q <= '0;
      pass_q   <= '0;
      direct_q <= 1'b0;
      arm_q    <= 1'b0;
      set_q    <= '0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
      rl_q     <= 1'b0;
`ifdef MATRIX_ACCEL_SCHED_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
      direct_q <= direct_d;
      arm_q    <= arm_d;
      set_q    <= set_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
      rl_q     <= rl_d;
`ifdef MATRIX_ACCEL_SCHED_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule
